down_conv: RTL and testbench
============================

// Module: down_conv
// PURPOSE
//  Receive-side counterpart of the TX zero-stuffing interpolator: integrate-and-dump decimator for
//  I/Q (a/b) sample pairs. Sums DECIM = 2**DECIM_LOG2 consecutive accepted input pairs per channel
//  and emits their mean as one output pair. Sits between the RX front end and the demodulator.
// PARAMETERS
//  DECIM_LOG2  3   log2 of decimation factor; legal range 1..6 (DECIM 2..64)
// PORTS
//  clk        in   1   single clock, all state updates on posedge
//  rst_n      in   1   asynchronous, active-low reset
//  x_a_i      in   16  input sample, channel a, signed two's complement
//  x_b_i      in   16  input sample, channel b, signed two's complement
//  x_valid_i  in   1   input pair valid
//  x_ready_o  out  1   input pair can be accepted this cycle (combinational)
//  y_a_o      out  16  decimated sample, channel a, signed, registered
//  y_b_o      out  16  decimated sample, channel b, signed, registered
//  y_valid_o  out  1   output pair valid, registered
//  y_ready_i  in   1   downstream accepts output pair
// BEHAVIOUR
//  - Accept: acc_x = x_valid_i & x_ready_o. Transfer out: y_valid_o & y_ready_i.
//  - phase[DECIM_LOG2-1:0]: counts accepted pairs; +1 per accept; wraps DECIM-1 -> 0.
//  - acc_a/acc_b: signed, 16+DECIM_LOG2 bits. Accept at phase 0: acc <= sext(x) (load, no clear cycle).
//    Other phases: acc <= acc + sext(x). No overflow possible at this width.
//  - Dump: accept at phase DECIM-1 -> sum = acc + sext(x); y_*_o <= sum >>> DECIM_LOG2
//    (arithmetic shift, i.e. floor); y_valid_o <= 1. Latency: y_valid_o high the cycle after
//    the DECIM-th accept.
//  - y_valid_o clears after a transfer out unless a dump occurs in the same cycle, in which case
//    it stays 1 and y_* takes the new value (back-to-back dumps, no bubble).
//  - y_*_o hold their value while y_valid_o=1 and y_ready_i=0.
//  - x_ready_o = !(phase==DECIM-1 & y_valid_o & !y_ready_i): the block stalls only on the final
//    sample of a block while the previous result is still unread. Phases 0..DECIM-2 are always
//    accepted, so a full block is buffered in the accumulators.
//  - x_valid_i gaps: phase and acc hold; only accepted pairs count toward the block.
//  - Reset (any time, incl. mid-block): phase=0, acc_a=acc_b=0, y_a_o=y_b_o=0, y_valid_o=0.
//    The partial block is discarded. x_ready_o=1 while in reset and after reset.
// CONFIGURATION
//  DOWN_CONV_ROUND_EN defined: dump value = (sum + 2**(DECIM_LOG2-1)) >>> DECIM_LOG2
//    (round half up). This cannot overflow: max is (32767*DECIM + DECIM/2) >>> L = 32767.
//  Not defined: truncation (floor) as above. No other behaviour differs.
// STRUCTURE
//  - modem_pkg: SAMPLE_W=16, DECIM_LOG2 default, shared by up/down converters.
//  - Sub-module down_conv_acc (one per channel: load/add/dump plus rounding). down_conv holds the
//    phase counter, the handshake logic, y_valid_o, and two down_conv_acc instances.
// TESTING
//  1. x_a=100, x_b=-100, x_valid_i=1, y_ready_i=1 held -> y=(100,-100), one y_valid pulse per
//     8 cycles; first one the cycle after the 8th accept.
//  2. a=0..7, b=-1 each -> trunc: y_a=3, y_b=-1. With DOWN_CONV_ROUND_EN: y_a=4, y_b=-1.
//  3. All 32767 -> y=32767. All -32768 -> y=-32768, in both configurations.
//  4. y_ready_i=0 after the first dump -> y held; x_ready_o=1 for the next 7 accepts, then 0 at
//     phase 7. Raise y_ready_i -> 8th pair accepted in the same cycle; new y the next cycle with
//     y_valid_o staying 1.
//  5. x_valid_i toggling 1,0,0,1,... -> the same y values as in scenario 1; dump only after 8 accepts.
//  6. Assert rst_n=0 after 5 accepts -> y_valid_o=0, y=0 immediately; the next result uses 8 fresh
//     pairs only.

Source files
------------

// File: rtl/modem_pkg.sv
// modem_pkg: shared sample width and default decimation for the up/down converters
package modem_pkg;
  localparam int SAMPLE_W = 16;
  localparam int DECIM_LOG2_DEF = 3;
endpackage

// File: rtl/down_conv_acc.sv
// down_conv_acc: one-channel integrate-and-dump accumulator; DOWN_CONV_ROUND_EN selects
// round-half-up instead of floor on the dumped mean
module down_conv_acc
  import modem_pkg::*;
#(
  parameter int L = DECIM_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                acc_i,
  input  logic                load_i,
  input  logic                dump_i,
  input  logic [SAMPLE_W-1:0] x_i,
  output logic [SAMPLE_W-1:0] y_o
);
  localparam int AW = SAMPLE_W + L;
`ifdef DOWN_CONV_ROUND_EN
  localparam logic signed [AW-1:0] HALF = AW'(2 ** (L - 1));
`else
  localparam logic signed [AW-1:0] HALF = '0;
`endif
  logic signed [AW-1:0] acc_q, acc_d, sum, rnd;
  logic [SAMPLE_W-1:0] y_q, y_d;
  // the first sample of a block loads directly, so there is no clear cycle between blocks
  always_comb begin
    sum   = (load_i ? '0 : acc_q) + AW'($signed(x_i));
    rnd   = sum + HALF;
    acc_d = acc_i ? sum : acc_q;
    y_d   = dump_i ? SAMPLE_W'(rnd >>> L) : y_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      y_q   <= '0;
    end else begin
      acc_q <= acc_d;
      y_q   <= y_d;
    end
  end
  assign y_o = y_q;
endmodule

// File: rtl/down_conv.sv
// down_conv: I/Q integrate-and-dump decimator by 2**DECIM_LOG2 with valid/ready on both sides;
// define DOWN_CONV_ROUND_EN for round-half-up output instead of floor
module down_conv
  import modem_pkg::*;
#(
  parameter int DECIM_LOG2 = DECIM_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] x_a_i,
  input  logic [SAMPLE_W-1:0] x_b_i,
  input  logic                x_valid_i,
  output logic                x_ready_o,
  output logic [SAMPLE_W-1:0] y_a_o,
  output logic [SAMPLE_W-1:0] y_b_o,
  output logic                y_valid_o,
  input  logic                y_ready_i
);
  logic [DECIM_LOG2-1:0] phase_q, phase_d;
  logic y_valid_q, y_valid_d, last, acc_x, dump;
  // only the block-closing sample waits for the previous result to drain
  always_comb begin
    last      = &phase_q;
    x_ready_o = !(last && y_valid_q && !y_ready_i);
    acc_x     = x_valid_i && x_ready_o;
    dump      = acc_x && last;
    phase_d   = acc_x ? phase_q + 1'b1 : phase_q;
    y_valid_d = dump ? 1'b1 : (y_ready_i ? 1'b0 : y_valid_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= '0;
      y_valid_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      y_valid_q <= y_valid_d;
    end
  end
  assign y_valid_o = y_valid_q;
  down_conv_acc #(.L(DECIM_LOG2)) u_acc_a (
    .clk(clk), .rst_n(rst_n), .acc_i(acc_x), .load_i(phase_q == '0), .dump_i(dump),
    .x_i(x_a_i), .y_o(y_a_o)
  );
  down_conv_acc #(.L(DECIM_LOG2)) u_acc_b (
    .clk(clk), .rst_n(rst_n), .acc_i(acc_x), .load_i(phase_q == '0), .dump_i(dump),
    .x_i(x_b_i), .y_o(y_b_o)
  );
endmodule

// File: tb/tb_down_conv.sv
// tb_down_conv: directed scenarios plus random traffic against a block-mean reference model
module tb_down_conv;
  localparam int D = 8;
`ifdef DOWN_CONV_ROUND_EN
  localparam int ROUND = 1;
`else
  localparam int ROUND = 0;
`endif
  logic clk = 0, rst_n = 1, x_valid_i = 0, y_ready_i = 1;
  logic [15:0] x_a_i = '0, x_b_i = '0, y_a_o, y_b_o;
  logic x_ready_o, y_valid_o;
  int vecs = 0, errs = 0;
  int cnt = 0, ea = 0, eb = 0;
  longint sa = 0, sb = 0;
  bit ov = 0;
  down_conv dut (
    .clk(clk), .rst_n(rst_n), .x_a_i(x_a_i), .x_b_i(x_b_i), .x_valid_i(x_valid_i),
    .x_ready_o(x_ready_o), .y_a_o(y_a_o), .y_b_o(y_b_o), .y_valid_o(y_valid_o),
    .y_ready_i(y_ready_i)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, longint got, longint exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // mean of D samples with floor division, optionally rounding half up
  function automatic int mean(longint s);
    longint t = s + (ROUND ? D / 2 : 0);
    longint q = t / D;
    if (t % D != 0 && t < 0) q--;
    return int'(q);
  endfunction
  task automatic step(bit v, int a, int b, bit r);
    bit rdy;
    @(negedge clk);
    x_valid_i = v; x_a_i = 16'(a); x_b_i = 16'(b); y_ready_i = r;
    #1;
    rdy = !(cnt == D - 1 && ov && !r);
    chk("x_ready", longint'(x_ready_o), longint'(rdy));
    if (r) ov = 0;
    if (v && rdy) begin
      sa += a; sb += b; cnt++;
      if (cnt == D) begin
        ea = mean(sa); eb = mean(sb); ov = 1; cnt = 0; sa = 0; sb = 0;
      end
    end
    @(posedge clk); #1;
    chk("y_valid", longint'(y_valid_o), longint'(ov));
    if (ov) begin
      chk("y_a", longint'($signed(y_a_o)), longint'(ea));
      chk("y_b", longint'($signed(y_b_o)), longint'(eb));
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    x_valid_i = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_y_valid", longint'(y_valid_o), 0);
    chk("rst_y_a", longint'($signed(y_a_o)), 0);
    chk("rst_y_b", longint'($signed(y_b_o)), 0);
    chk("rst_x_ready", longint'(x_ready_o), 1);
    cnt = 0; sa = 0; sb = 0; ov = 0; ea = 0; eb = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 100, -100, 1);
    for (int i = 0; i < 8; i++) step(1, i, -1, 1);
    chk("s2_a", longint'($signed(y_a_o)), ROUND ? 4 : 3);
    chk("s2_b", longint'($signed(y_b_o)), -1);
    for (int i = 0; i < 8; i++) step(1, 32767, 32767, 1);
    chk("s3_max", longint'($signed(y_a_o)), 32767);
    for (int i = 0; i < 8; i++) step(1, -32768, -32768, 1);
    chk("s3_min", longint'($signed(y_b_o)), -32768);
    for (int i = 0; i < 16; i++) step(1, 10 * i, -7 * i, 0);
    step(1, 5, 5, 0);
    step(1, 5, 5, 0);
    step(1, 9, 9, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 24; i++) step(i % 3 == 0, 100, -100, 1);
    for (int i = 0; i < 5; i++) step(1, 1000, 1000, 1);
    do_reset();
    for (int i = 0; i < 8; i++) step(1, -3 * i, 2 * i + 1, 1);
    chk("s6_a", longint'($signed(y_a_o)), ROUND ? -10 : -11);
    for (int i = 0; i < 2000; i++) begin
      int a, b;
      a = int'($signed(16'($urandom)));
      b = int'($signed(16'($urandom)));
      if ($urandom_range(7) == 0) a = $urandom_range(1) ? 32767 : -32768;
      if ($urandom_range(7) == 0) b = $urandom_range(1) ? 32767 : -32768;
      step($urandom_range(3) != 0, a, b, $urandom_range(2) != 0);
      if (i == 1000) do_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
